// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - AXI4 slave memory with independent read/write engines; optional AXI_MEM_RESP_STALL_EN stall injection
module axi_mem_responder #(
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 6,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ((off >> BYTE_SHIFT) >= ADDR_WIDTH'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> BYTE_SHIFT);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + (ADDR_WIDTH'(1) << size);
    endfunction

    logic hs_stall;
    logic exit_stall;

`ifdef AXI_MEM_RESP_STALL_EN
    logic [15:0] lfsr;

    // Free-running LFSR that decides when handshakes and state exits are throttled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign hs_stall   = (lfsr[1:0] == 2'b00);
    assign exit_stall = (lfsr[3:2] == 2'b00);
`else
    assign hs_stall   = 1'b0;
    assign exit_stall = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write engine ----------------
    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   wr_id;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len, wr_cnt;
    logic [2:0]            wr_size;
    logic [1:0]            wr_burst, wr_resp, wr_beat_resp;
    logic                  wr_size_err, wr_burst_bad, wr_oor, wr_last_beat, wr_en;
    logic                  aw_hs, w_hs;

    assign aw_hs        = s_axi_awvalid && s_axi_awready;
    assign w_hs         = s_axi_wvalid && s_axi_wready;
    assign wr_oor       = out_of_range(wr_addr);
    assign wr_last_beat = (wr_cnt == wr_len);
    assign wr_beat_resp = wr_oor ? RESP_DECERR :
                          (wr_size_err || wr_burst_bad || (s_axi_wlast != wr_last_beat)) ? RESP_SLVERR :
                          RESP_OKAY;
    assign wr_en        = w_hs && !wr_oor && !wr_size_err;

    // Write state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write next-state: one AW, len+1 W beats, then hold B until accepted
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && wr_last_beat) w_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write outputs; the final beat is held off while an exit stall is active
    always_comb begin
        s_axi_awready = rstn && (w_state == W_IDLE) && !hs_stall;
        s_axi_wready  = rstn && (w_state == W_DATA) && !hs_stall && !(wr_last_beat && exit_stall);
        s_axi_bvalid  = (w_state == W_RESP);
        s_axi_bid     = (w_state == W_RESP) ? wr_id : '0;
        s_axi_bresp   = (w_state == W_RESP) ? wr_resp : RESP_OKAY;
    end

    // Write burst context; response is sticky and codes order by priority numerically
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_id <= '0; wr_addr <= '0; wr_len <= '0; wr_cnt <= '0;
            wr_size <= '0; wr_burst <= '0; wr_resp <= RESP_OKAY;
            wr_size_err <= 1'b0; wr_burst_bad <= 1'b0;
        end else if (aw_hs) begin
            wr_id        <= s_axi_awid;
            wr_addr      <= s_axi_awaddr;
            wr_len       <= s_axi_awlen;
            wr_cnt       <= '0;
            wr_size      <= s_axi_awsize;
            wr_burst     <= s_axi_awburst;
            wr_resp      <= RESP_OKAY;
            wr_size_err  <= int'(s_axi_awsize) > BYTE_SHIFT;
            wr_burst_bad <= s_axi_awburst[1];
        end else if (w_hs) begin
            wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
            wr_cnt  <= wr_cnt + 8'd1;
            if (wr_beat_resp > wr_resp) wr_resp <= wr_beat_resp;
        end
    end

    // RAM byte-lane write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) mem[word_index(wr_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            rd_len, rd_cnt;
    logic [2:0]            rd_size;
    logic [1:0]            rd_burst, rd_resp;
    logic                  rd_size_err, rd_burst_bad;
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  ar_hs, r_hs, rd_last_beat;

    assign ar_hs        = s_axi_arvalid && s_axi_arready;
    assign r_hs         = s_axi_rvalid && s_axi_rready;
    assign rd_last_beat = (rd_cnt == rd_len);

    // Read state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read next-state: every beat is a fetch cycle followed by a data cycle
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_FETCH;
            R_FETCH: if (!exit_stall) r_next = R_DATA;
            R_DATA:  if (s_axi_rready) r_next = rd_last_beat ? R_IDLE : R_FETCH;
            default: r_next = R_IDLE;
        endcase
    end

    // Read outputs; error beats carry zero data
    always_comb begin
        s_axi_arready = rstn && (r_state == R_IDLE) && !hs_stall;
        s_axi_rvalid  = (r_state == R_DATA);
        s_axi_rid     = (r_state == R_DATA) ? rd_id : '0;
        s_axi_rresp   = (r_state == R_DATA) ? rd_resp : RESP_OKAY;
        s_axi_rlast   = (r_state == R_DATA) && rd_last_beat;
        s_axi_rdata   = ((r_state == R_DATA) && (rd_resp == RESP_OKAY)) ? mem_q : '0;
    end

    // Read burst context and per-beat response, resolved during the fetch cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_id <= '0; rd_addr <= '0; rd_len <= '0; rd_cnt <= '0;
            rd_size <= '0; rd_burst <= '0; rd_resp <= RESP_OKAY;
            rd_size_err <= 1'b0; rd_burst_bad <= 1'b0;
        end else if (ar_hs) begin
            rd_id        <= s_axi_arid;
            rd_addr      <= s_axi_araddr;
            rd_len       <= s_axi_arlen;
            rd_cnt       <= '0;
            rd_size      <= s_axi_arsize;
            rd_burst     <= s_axi_arburst;
            rd_size_err  <= int'(s_axi_arsize) > BYTE_SHIFT;
            rd_burst_bad <= s_axi_arburst[1];
        end else if (r_state == R_FETCH) begin
            rd_resp <= out_of_range(rd_addr) ? RESP_DECERR :
                       (rd_size_err || rd_burst_bad) ? RESP_SLVERR : RESP_OKAY;
        end else if (r_hs && !rd_last_beat) begin
            rd_addr <= next_addr(rd_addr, rd_size, rd_burst);
            rd_cnt  <= rd_cnt + 8'd1;
        end
    end

    // RAM read port, read-first against a same-cycle write
    always_ff @(posedge clk) begin
        if (r_state == R_FETCH) mem_q <= mem[word_index(rd_addr)];
    end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- Synthesizable AXI4 slave memory that answers the accelerator's m_axi master: serves read bursts (weights/inputs) and absorbs write bursts (outputs).
- Replaces the behavioural VIP memory in FPGA and emulation builds; sits directly on the m_axi port of the top-level accelerator.
- Independent read and write engines, one outstanding transaction per direction, word-addressed internal RAM.

Parameters:
- DATA_WIDTH, 128, AXI data width in bits; power of two, 32 or more.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 6, AXI ID width.
- STRB_WIDTH, DATA_WIDTH/8, strobe width; one bit per byte lane.
- DEPTH, 4096, RAM depth in DATA_WIDTH words.
- BASE_ADDR, 0, byte address that maps to RAM word 0.

Ports:
- clk input 1: clock.
- rstn input 1: asynchronous active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst input ID_WIDTH/ADDR_WIDTH/8/3/2: write address.
- s_axi_awvalid input 1, s_axi_awready output 1: AW handshake.
- s_axi_wdata/wstrb/wlast input DATA_WIDTH/STRB_WIDTH/1: write data.
- s_axi_wvalid input 1, s_axi_wready output 1: W handshake.
- s_axi_bid output ID_WIDTH, s_axi_bresp output 2: write response.
- s_axi_bvalid output 1, s_axi_bready input 1: B handshake.
- s_axi_arid/araddr/arlen/arsize/arburst input ID_WIDTH/ADDR_WIDTH/8/3/2: read address.
- s_axi_arvalid input 1, s_axi_arready output 1: AR handshake.
- s_axi_rid output ID_WIDTH, s_axi_rdata output DATA_WIDTH, s_axi_rresp output 2, s_axi_rlast output 1: read data.
- s_axi_rvalid output 1, s_axi_rready input 1: R handshake.
- Lock, cache and prot are not ports; the integrator leaves them unconnected.

Behaviour:
- Reset (async, rstn=0): every valid/ready output is 0, and all id/resp/data/last outputs are 0. RAM contents are not reset.
- Reset asserted mid-burst: the burst is abandoned and both FSMs go to IDLE.
- First cycle after reset release: awready=1 and arready=1.
- Address mapping:
  - word index = (addr - BASE_ADDR) >> log2(STRB_WIDTH); the low bits are ignored (aligned word).
  - INCR: addr += 2^size per beat. FIXED: addr is constant. WRAP(2'b10) and burst 2'b11: treated as INCR, and the response is SLVERR.
  - A beat is out of range if addr < BASE_ADDR or index >= DEPTH. Such a beat does no RAM access and returns DECERR (2'b11).
  - size > log2(STRB_WIDTH): SLVERR (2'b10); writes in that burst are suppressed.
  - 4 KB crossing is not checked.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch id/addr/len/size/burst and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the byte lanes whose wstrb bit is 1 (unless the beat is in error) and advances the address and beat count.
  - The beat with count==len ends the burst and goes to W_RESP.
  - A wlast mismatch (wlast=1 before beat len, or wlast=0 on beat len) gives SLVERR. The burst length is still len+1 beats.
  - W_RESP: bvalid=1 with bid=latched id. bresp is sticky over the burst, priority DECERR > SLVERR > OKAY. Hold until bready, then W_IDLE (awready=1 the next cycle).
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch the fields and go to R_FETCH.
  - R_FETCH: one-cycle synchronous RAM read, then R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=1 on beat len. rresp is per beat. rdata=0 for error beats.
  - On the rready handshake: go to R_IDLE if this was the last beat, else R_FETCH with the next address.
  - Throughput is 1 beat per 2 cycles. AR-to-first-rvalid latency is 2 cycles.
- Handshake stability: rvalid/bvalid, once high, stay high with stable payload until accepted. Valid outputs never depend combinationally on the ready inputs.
- Simultaneous RAM read and write to the same word in one cycle: the read returns the old data (read-first).
- len=255 is supported; the beat counter is 8 bits.
- AR and AW are accepted concurrently and are fully independent.

Optional Feature:
- AXI_MEM_RESP_STALL_EN defined:
  - A 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1; advances every cycle; reset to the seed) throttles the block.
  - awready, wready and arready are forced to 0 when lfsr[1:0]==0.
  - The exits from R_FETCH and W_DATA-to-bvalid wait while lfsr[3:2]==0.
  - Stalls never drop an already-asserted valid.
- Macro undefined: no stalls and no LFSR logic; timing is exactly as above.

Test Plan:
1. Write len=0, size=4, awaddr=BASE+0x10, wdata=128'h0F0E..00, wstrb all ones, awid=5, then read the same location: bid=5, bresp=0; rdata matches, rresp=0, rlast=1, rid matches arid.
2. INCR write len=7 (beats 0..7, data=beat number) at BASE, then read len=7: 8 beats, data 0..7, rlast only on beat 7; first rvalid 2 cycles after the AR handshake.
3. Word preloaded all 0xFF, then write 0 with wstrb=16'h00FF: readback has the low 8 bytes 00 and the high 8 bytes FF.
4. Read len=1 at BASE+DEPTH*16: 2 beats, rresp=2'b11, rdata=0. A write at the same address: bresp=2'b11, RAM unchanged.
5. FIXED write len=3 with data A,B,C,D: the word reads D. Write len=1 with wlast high on beat 0: bresp=2'b10.
6. rready held low for 10 cycles mid-burst: rvalid, rdata and rlast stable. Then rstn pulsed mid-burst: all valids 0 during reset; awready=arready=1 the cycle after release.
